// File: rtl/fuse_rd_arb_if.sv
// Bundle of requester, fuse-memory and response signals shared by the arbiter and its users.
interface fuse_rd_arb_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0][31:0] req_addr_i;
  logic [NUM_REQ-1:0][3:0]  req_len_i;
  logic                     lock_i;
  logic                     fuse_req_o;
  logic [31:0]              fuse_addr_o;
  logic [31:0]              fuse_rdata_i;
  logic [NUM_REQ-1:0]       rsp_valid_o;
  logic [31:0]              rsp_data_o;
  logic                     rsp_err_o;
  logic                     rsp_last_o;
  logic                     busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, lock_i, fuse_rdata_i,
    output req_ready_o, fuse_req_o, fuse_addr_o, rsp_valid_o, rsp_data_o,
           rsp_err_o, rsp_last_o, busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, lock_i, fuse_rdata_i,
    input  req_ready_o, fuse_req_o, fuse_addr_o, rsp_valid_o, rsp_data_o,
           rsp_err_o, rsp_last_o, busy_o
  );
endinterface

// File: rtl/fuse_rd_arb.sv
// Round-robin burst arbiter in front of a fuse array: one word issued per cycle,
// each answered two cycles later with data or a range/lock denial.
module fuse_rd_arb #(
  parameter int NUM_REQ  = 3,
  parameter int MEM_SIZE = 100,
  parameter int LOCK_LO  = 24,
  parameter int LOCK_HI  = 99
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fuse_rd_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t             state_q;
  logic [NUM_REQ-1:0] ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [31:0]        addr_q;
  logic [3:0]         rem_q;
  logic               s1_valid_q;
  logic               s1_ok_q;
  logic               s1_last_q;
  logic [NUM_REQ-1:0] s1_gnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;
  logic               rsp_last_q;

  logic [NUM_REQ-1:0] mask_d;
  logic [NUM_REQ-1:0] masked_d;
  logic [NUM_REQ-1:0] choose_d;
  logic [NUM_REQ-1:0] gnt_oh_d;
  logic               grant_d;
  logic               issue_d;
  logic               in_lock_d;
  logic               ok_d;
  logic [35:0]        sel_d;
  logic [35:0]        sel_chain [NUM_REQ+1];

  // Pointer is kept one-hot; requests at or above it win first, else wrap to the lowest.
  always_comb begin
    mask_d   = ~(ptr_q - ONE);
    masked_d = bus.req_valid_i & mask_d;
    choose_d = (|masked_d) ? masked_d : bus.req_valid_i;
    gnt_oh_d = choose_d & ~(choose_d - ONE);
    grant_d  = (state_q == IDLE) && (|bus.req_valid_i) && !rst_i;
  end

  assign sel_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign sel_chain[gi+1] = sel_chain[gi] |
             (gnt_oh_d[gi] ? {bus.req_len_i[gi], bus.req_addr_i[gi]} : 36'd0);
    end
  endgenerate
  assign sel_d = sel_chain[NUM_REQ];

  // lock_i is looked at only in the cycle the word is issued.
  always_comb begin
    issue_d   = (state_q == ISSUE);
    in_lock_d = (addr_q >= 32'(LOCK_LO)) && (addr_q <= 32'(LOCK_HI));
    ok_d      = (addr_q < 32'(MEM_SIZE)) && !(bus.lock_i && in_lock_d);
  end

  assign bus.req_ready_o = grant_d ? gnt_oh_d : '0;
  assign bus.fuse_req_o  = issue_d && ok_d;
  assign bus.fuse_addr_o = (issue_d && ok_d) ? addr_q : 32'd0;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_last_o  = rsp_last_q;
  assign bus.busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= ONE;
      gnt_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_gnt_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      // Stage 1 tracks the word whose fuse data arrives next cycle.
      s1_valid_q  <= issue_d;
      s1_ok_q     <= issue_d && ok_d;
      s1_last_q   <= issue_d && (rem_q == 4'd0);
      s1_gnt_q    <= gnt_q;
      rsp_valid_q <= s1_valid_q ? s1_gnt_q : '0;
      rsp_data_q  <= (s1_valid_q && s1_ok_q) ? bus.fuse_rdata_i : 32'd0;
      rsp_err_q   <= s1_valid_q && !s1_ok_q;
      rsp_last_q  <= s1_valid_q && s1_last_q;

      case (state_q)
        IDLE: begin
          if (grant_d) begin
            gnt_q   <= gnt_oh_d;
            addr_q  <= sel_d[31:0];
            rem_q   <= sel_d[35:32];
            ptr_q   <= {gnt_oh_d[NUM_REQ-2:0], gnt_oh_d[NUM_REQ-1]};
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          addr_q <= addr_q + 32'd1;
          rem_q  <= rem_q - 4'd1;
          if (rem_q == 4'd0) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (rsp_last_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuse_rd_arb.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_fuse_rd_arb;

  localparam int N   = 3;
  localparam int MEM = 100;
  localparam int LLO = 24;
  localparam int LHI = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fuse_rd_arb_if #(.NUM_REQ(N)) bus();

  fuse_rd_arb #(.NUM_REQ(N), .MEM_SIZE(MEM), .LOCK_LO(LLO), .LOCK_HI(LHI)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Fuse array: data for a strobe appears the next cycle, junk otherwise.
  always @(posedge clk) begin
    bus.fuse_rdata_i <= bus.fuse_req_o ? mem_word(bus.fuse_addr_o) : $urandom();
  end

  logic [N-1:0] gl;
  always @(posedge clk) gl <= bus.req_ready_o;

  // ---------------- reference model and per-cycle compare ----------------
  int          cyc = 0;
  int          m_ptr = 0, m_free = 0, m_grant = -10;
  bit          iss_act [64];
  logic [31:0] iss_addr[64];
  int          iss_g   [64];
  bit          iss_last[64];
  bit          rsp_act [64];
  int          rsp_g   [64];
  logic [31:0] rsp_dat [64];
  bit          rsp_err [64];
  bit          rsp_lst [64];

  logic [N-1:0] e_ready, e_rv;
  logic         e_freq, e_err, e_last, e_busy, ok;
  logic [31:0]  e_faddr, e_data, a;
  int           s, t, g, k2, n;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
      chk("rst_freq",  32'(bus.fuse_req_o),  32'd0);
      chk("rst_faddr", bus.fuse_addr_o,      32'd0);
      chk("rst_rvalid", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_rdata", bus.rsp_data_o,       32'd0);
      chk("rst_rerr",  32'(bus.rsp_err_o),   32'd0);
      chk("rst_rlast", 32'(bus.rsp_last_o),  32'd0);
      chk("rst_busy",  32'(bus.busy_o),      32'd0);
      m_ptr = 0; m_free = 0; m_grant = -10;
      for (int i = 0; i < 64; i++) begin
        iss_act[i] = 1'b0;
        rsp_act[i] = 1'b0;
      end
    end else begin
      s = cyc % 64;
      e_ready = '0;
      if (cyc >= m_free && bus.req_valid_i != '0) begin
        g = -1;
        for (int i = 0; i < N; i++) begin
          k2 = (m_ptr + i) % N;
          if (g < 0 && bus.req_valid_i[k2]) g = k2;
        end
        e_ready = N'(1) << g;
        n = int'(bus.req_len_i[g]) + 1;
        a = bus.req_addr_i[g];
        for (int j = 0; j < n; j++) begin
          t = (cyc + 1 + j) % 64;
          iss_act[t]  = 1'b1;
          iss_addr[t] = a + 32'(j);
          iss_g[t]    = g;
          iss_last[t] = (j == n - 1);
        end
        m_grant = cyc;
        m_free  = cyc + n + 3;
        m_ptr   = (g + 1) % N;
      end
      e_freq = 1'b0; e_faddr = 32'd0;
      if (iss_act[s]) begin
        a  = iss_addr[s];
        ok = (a < MEM) && !(bus.lock_i && a >= LLO && a <= LHI);
        e_freq  = ok;
        e_faddr = ok ? a : 32'd0;
        t = (cyc + 2) % 64;
        rsp_act[t] = 1'b1;
        rsp_g[t]   = iss_g[s];
        rsp_dat[t] = ok ? mem_word(a) : 32'd0;
        rsp_err[t] = !ok;
        rsp_lst[t] = iss_last[s];
        iss_act[s] = 1'b0;
      end
      e_rv = '0; e_data = 32'd0; e_err = 1'b0; e_last = 1'b0;
      if (rsp_act[s]) begin
        e_rv   = N'(1) << rsp_g[s];
        e_data = rsp_dat[s];
        e_err  = rsp_err[s];
        e_last = rsp_lst[s];
        rsp_act[s] = 1'b0;
      end
      e_busy = (cyc > m_grant) && (cyc < m_free);
      chk("ready",  32'(bus.req_ready_o), 32'(e_ready));
      chk("freq",   32'(bus.fuse_req_o),  32'(e_freq));
      chk("faddr",  bus.fuse_addr_o,      e_faddr);
      chk("rvalid", 32'(bus.rsp_valid_o), 32'(e_rv));
      chk("rdata",  bus.rsp_data_o,       e_data);
      chk("rerr",   32'(bus.rsp_err_o),   32'(e_err));
      chk("rlast",  32'(bus.rsp_last_o),  32'(e_last));
      chk("busy",   32'(bus.busy_o),      32'(e_busy));
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 30));
      1:       return 32'($urandom_range(20, 30));
      2:       return 32'($urandom_range(90, 110));
      3:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: return 32'($urandom_range(0, 120));
    endcase
  endfunction

  logic [2:0] exp_oh [4];
  logic [2:0] got_oh [4];
  int         got_cyc[4];
  int         ng;

  initial begin
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.lock_i      = 1'b0;
    exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word from requester 0
    @(negedge clk);
    bus.req_valid_i = 3'b001; bus.req_addr_i[0] = 32'd0; bus.req_len_i[0] = 4'd0;
    #2 chk("d1_ready", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk); bus.req_valid_i = '0;
    #2 chk("d1_freq", 32'(bus.fuse_req_o), 32'h1);
    chk("d1_faddr", bus.fuse_addr_o, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 chk("d1_rvalid", 32'(bus.rsp_valid_o), 32'h1);
    chk("d1_rdata", bus.rsp_data_o, 32'h01234567);
    chk("d1_rlast", 32'(bus.rsp_last_o), 32'h1);
    chk("d1_rerr", 32'(bus.rsp_err_o), 32'h0);
    @(negedge clk);
    #2 chk("d1_busy", 32'(bus.busy_o), 32'h0);

    // Four-word burst from requester 1 ending at the top of the array
    @(negedge clk);
    bus.req_valid_i = 3'b010; bus.req_addr_i[1] = 32'd96; bus.req_len_i[1] = 4'd3;
    #2 chk("d2_ready", 32'(bus.req_ready_o), 32'h2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid_i = '0;
      #2;
      if (k <= 4) begin
        chk("d2_freq", 32'(bus.fuse_req_o), 32'h1);
        chk("d2_faddr", bus.fuse_addr_o, 32'd95 + 32'(k));
      end
      if (k >= 3) begin
        chk("d2_rvalid", 32'(bus.rsp_valid_o), 32'h2);
        chk("d2_rlast", 32'(bus.rsp_last_o), (k == 6) ? 32'h1 : 32'h0);
      end
    end
    @(negedge clk);
    #2 chk("d2_busy", 32'(bus.busy_o), 32'h0);

    // Locked window: every word denied
    @(negedge clk);
    bus.lock_i = 1'b1;
    bus.req_valid_i = 3'b100; bus.req_addr_i[2] = 32'd98; bus.req_len_i[2] = 4'd3;
    #2 chk("d3_ready", 32'(bus.req_ready_o), 32'h4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid_i = '0;
      #2;
      if (k <= 4) chk("d3_freq", 32'(bus.fuse_req_o), 32'h0);
      if (k >= 3) begin
        chk("d3_rerr", 32'(bus.rsp_err_o), 32'h1);
        chk("d3_rdata", bus.rsp_data_o, 32'h0);
        chk("d3_rlast", 32'(bus.rsp_last_o), (k == 6) ? 32'h1 : 32'h0);
      end
    end
    @(negedge clk);

    // Unlocked: two in range, two past the end
    @(negedge clk);
    bus.lock_i = 1'b0;
    bus.req_valid_i = 3'b100;
    #2 chk("d3b_ready", 32'(bus.req_ready_o), 32'h4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid_i = '0;
      #2;
      if (k <= 4) begin
        chk("d3b_freq", 32'(bus.fuse_req_o), (k <= 2) ? 32'h1 : 32'h0);
        chk("d3b_faddr", bus.fuse_addr_o, (k <= 2) ? 32'd97 + 32'(k) : 32'h0);
      end
      if (k >= 3) begin
        chk("d3b_rerr", 32'(bus.rsp_err_o), (k >= 5) ? 32'h1 : 32'h0);
        chk("d3b_rdata", bus.rsp_data_o, (k >= 5) ? 32'h0 : mem_word(32'd95 + 32'(k)));
      end
    end
    @(negedge clk);

    // All three requesting continuously
    @(negedge clk);
    bus.req_addr_i[0] = 32'd5; bus.req_addr_i[1] = 32'd6; bus.req_addr_i[2] = 32'd7;
    bus.req_len_i = '0;
    bus.req_valid_i = 3'b111;
    ng = 0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      #2;
      if (bus.req_ready_o != '0 && ng < 4) begin
        got_oh[ng] = bus.req_ready_o;
        got_cyc[ng] = j;
        ng++;
      end
    end
    bus.req_valid_i = '0;
    chk("d4_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) begin
      chk("d4_gnt", 32'(got_oh[i]), 32'(exp_oh[i]));
      chk("d4_gap", 32'(got_cyc[i]), 32'(4 * i));
    end
    repeat (4) @(negedge clk);

    // Reset in the middle of a 16-word burst
    @(negedge clk);
    bus.req_valid_i = 3'b001; bus.req_addr_i[0] = 32'd10; bus.req_len_i[0] = 4'd15;
    #2 chk("d5_ready", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk); bus.req_valid_i = '0;
    #2 chk("d5_faddr", bus.fuse_addr_o, 32'd10);
    @(negedge clk);
    rst = 1'b1; bus.req_valid_i = 3'b101;
    #2 chk("d5_freq", 32'(bus.fuse_req_o), 32'h0);
    chk("d5_busy", 32'(bus.busy_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2 chk("d5_ready_after", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk); bus.req_valid_i = '0;
    repeat (22) @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = (c % 700 == 350);
      bus.lock_i = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < N; r++) begin
        if (gl[r] || !bus.req_valid_i[r]) begin
          bus.req_valid_i[r] = ($urandom_range(0, 2) != 0);
          bus.req_addr_i[r]  = rand_addr();
          bus.req_len_i[r]   = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_addr_i[r] = $urandom();
        end
      end
    end
    rst = 1'b0;
    bus.req_valid_i = '0;
    repeat (25) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
